// File: rtl/uart_pkg.sv
// Shared UART definitions: packet framing constants, transmitter FSM encoding
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int   PKT_LEN    = 11;
    localparam int   OVERSAMPLE = 16;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Zero-extending the data to 32 bits leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts sample-enable ticks 0..OVERSAMPLE-1 while running and
// flags the tick that completes the current bit period.
module tx_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    input  logic tick,
    output logic bit_end
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = run & tick & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/data_transmission_framer.sv
// UART transmitter: frames one byte as start, data LSB first, parity, stop and
// shifts it onto TxD, one bit per OVERSAMPLE sample-enable ticks.
module data_transmission_framer
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Tx_EN,
    input  logic              Tx_sample_ENABLE,
    input  logic              Tx_WR,
    input  logic [DATA_W-1:0] Tx_DATA,
    output logic              TxD,
    output logic              Tx_BUSY,
    output logic              Tx_DONE,
    output logic              Tx_WR_ERR,
    output logic [2:0]        state_dbg
);

    localparam int FRAME_W = DATA_W + 3;
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_t          state, state_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
    logic               accept, wr_err, bit_end, stop_end;

    // Host handshake: a Tx_WR strobe is taken only when idle and enabled;
    // any other strobe is dropped and flagged with a one-cycle Tx_WR_ERR.
    assign accept    = (state == ST_IDLE) & Tx_WR & Tx_EN;
    assign wr_err    = Tx_WR & ~accept;
    assign stop_end  = (state == ST_STOP) & bit_end;
    assign Tx_BUSY   = (state != ST_IDLE);
    assign TxD       = shreg[0];
    assign state_dbg = state;

    tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .run     (Tx_BUSY),
        .tick    (Tx_sample_ENABLE),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        // Ones shift in from the top so the line rests at the stop level afterwards.
        if (bit_end) begin
            shreg_nxt = {1'b1, shreg[FRAME_W-1:1]};
        end
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_START;
                    shreg_nxt = {STOP_BIT, parity_bit(32'(Tx_DATA), 1'(PARITY_ODD)),
                                 Tx_DATA, START_BIT};
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = ST_PARITY;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                    shreg_nxt = '1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                shreg_nxt = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '1;
            bit_idx   <= '0;
            Tx_DONE   <= 1'b0;
            Tx_WR_ERR <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_idx   <= bit_idx_nxt;
            Tx_DONE   <= stop_end;
            Tx_WR_ERR <= wr_err;
        end
    end

endmodule

// File: tb/tb_data_transmission_framer.sv
// Directed bench for data_transmission_framer: even- and odd-parity instances share
// stimulus; every bit of each frame is checked mid-bit and on its last clock.
module tb_data_transmission_framer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Tx_EN = 1'b0;
    logic       Tx_sample_ENABLE = 1'b0;
    logic       Tx_WR = 1'b0;
    logic [7:0] Tx_DATA = 8'h00;
    logic       txd_e, busy_e, done_e, err_e;
    logic       txd_o, busy_o, done_o, err_o;
    logic [2:0] st_e, st_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_ctr = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    data_transmission_framer #(.DATA_W(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut_e (
        .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_sample_ENABLE(Tx_sample_ENABLE),
        .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .TxD(txd_e), .Tx_BUSY(busy_e),
        .Tx_DONE(done_e), .Tx_WR_ERR(err_e), .state_dbg(st_e)
    );

    data_transmission_framer #(.DATA_W(8), .OVERSAMPLE(16), .PARITY_ODD(1)) dut_o (
        .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_sample_ENABLE(Tx_sample_ENABLE),
        .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .TxD(txd_o), .Tx_BUSY(busy_o),
        .Tx_DONE(done_o), .Tx_WR_ERR(err_o), .state_dbg(st_o)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic odd);
        return {1'b1, (^d) ^ odd, d, 1'b0};
    endfunction

    // ---------------- drivers ----------------
    // Advance to the next falling edge, count error pulses, and schedule a tick
    // on every 4th rising edge.
    task automatic cycle();
        @(negedge clk);
        err_cnt += int'(err_e);
        tick_ctr++;
        Tx_sample_ENABLE = (tick_ctr % 4 == 0);
    endtask

    // Write so the accept edge also carries a tick (which must not count).
    task automatic write_aligned(input logic [7:0] d);
        while (tick_ctr % 4 != 3) cycle();
        cycle();
        Tx_WR   = 1'b1;
        Tx_DATA = d;
        exp_q.push_back(d);
        cycle();
        Tx_WR   = 1'b0;
        Tx_DATA = ~d;
        check("start_bit_e", txd_e, 1'b0);
        check("start_bit_o", txd_o, 1'b0);
        check("busy_at_accept", busy_e, 1'b1);
    endtask

    // f = clocks from accept edge to the first counted tick.
    task automatic run_frame(input int f, input int wr_at, input int en_drop_at,
                             input bit chain, input logic [7:0] chain_d);
        logic [7:0]  d;
        logic [10:0] fe, fo;
        int          e0, end_k;
        d  = exp_q.pop_front();
        fe = frame_of(d, 1'b0);
        fo = frame_of(d, 1'b1);
        e0 = err_cnt;
        for (int k = 1; k <= f + 700; k++) begin
            cycle();
            if (k == wr_at) begin
                Tx_WR   = 1'b1;
                Tx_DATA = 8'hFF;
            end else if (k == wr_at + 1) begin
                Tx_WR = 1'b0;
            end
            if (k == en_drop_at) Tx_EN = 1'b0;
            for (int b = 0; b < 11; b++) begin
                end_k = f + 64 * b + 60;
                if (k == end_k - 32 || k == end_k - 1) begin
                    check($sformatf("d%02h_bit%0d_k%0d_e", d, b, k), txd_e, fe[b]);
                    check($sformatf("d%02h_bit%0d_k%0d_o", d, b, k), txd_o, fo[b]);
                end
            end
            if (k == f + 699) begin
                check("done_early", done_e, 1'b0);
                check("busy_before_end", busy_e, 1'b1);
            end
        end
        check("done_pulse_e", done_e, 1'b1);
        check("done_pulse_o", done_o, 1'b1);
        check("busy_cleared", busy_e, 1'b0);
        check("idle_after_stop", txd_e, 1'b1);
        check("wr_err_count", err_cnt - e0, (wr_at > 0) ? 1 : 0);
        Tx_EN = 1'b1;
        if (chain) begin
            Tx_WR   = 1'b1;
            Tx_DATA = chain_d;
            exp_q.push_back(chain_d);
            cycle();
            Tx_WR   = 1'b0;
            check("chain_start_e", txd_e, 1'b0);
            check("chain_busy", busy_e, 1'b1);
            check("chain_done_cleared", done_e, 1'b0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int bad;
        logic [7:0] dummy;

        repeat (5) cycle();
        check("rst_txd", txd_e, 1'b1);
        check("rst_busy", busy_e, 1'b0);
        check("rst_done", done_e, 1'b0);
        check("rst_err", err_e, 1'b0);
        check("rst_state", st_e, 3'd0);
        reset = 1'b1;
        Tx_EN = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (txd_e !== 1'b1 || busy_e !== 1'b0 || txd_o !== 1'b1) bad++;
        end
        check("idle_1000", bad, 0);

        write_aligned(8'hA5);
        run_frame(4, -1, -1, 1'b0, 8'h00);

        write_aligned(8'h07);
        run_frame(4, -1, -1, 1'b0, 8'h00);

        write_aligned(8'h3C);
        run_frame(4, 100, 300, 1'b1, 8'hFF);
        run_frame(3, -1, -1, 1'b0, 8'h00);

        // Reset in the middle of D3 (frame bit 4).
        write_aligned(8'h96);
        dummy = exp_q.pop_front();
        repeat (4 + 64 * 3 + 60 + 30) cycle();
        reset = 1'b0;
        #1;
        check("async_rst_txd", txd_e, 1'b1);
        check("async_rst_busy", busy_e, 1'b0);
        check("async_rst_state", st_e, 3'd0);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        write_aligned(8'h3C);
        run_frame(4, -1, -1, 1'b0, 8'h00);

        write_aligned(8'h00);
        run_frame(4, -1, -1, 1'b0, 8'h00);
        write_aligned(8'hFF);
        run_frame(4, -1, -1, 1'b0, 8'h00);
        write_aligned(8'h55);
        run_frame(4, -1, -1, 1'b0, 8'h00);

        // Write with the transmitter disabled.
        Tx_EN = 1'b0;
        cycle();
        bad = err_cnt;
        Tx_WR   = 1'b1;
        Tx_DATA = 8'h81;
        cycle();
        Tx_WR = 1'b0;
        check("dis_wr_err_pulse", err_e, 1'b1);
        check("dis_wr_err_pulse_o", err_o, 1'b1);
        check("dis_busy", busy_e, 1'b0);
        cycle();
        check("dis_err_one_clk", err_e, 1'b0);
        check("dis_err_count", err_cnt - bad, 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (txd_e !== 1'b1 || busy_e !== 1'b0) bad++;
        end
        check("dis_line_idle", bad, 0);
        Tx_EN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
